// File: rtl/counting_sorter_param_pkg.sv
// Shared types and helpers for the parametrised counting sorter.
package counting_sorter_param_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StEmit  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Width able to hold a bin count from 0 up to num inclusive.
  function automatic int unsigned cnt_width(input int unsigned num);
    return $clog2(num + 1);
  endfunction

endpackage

// File: rtl/counting_sorter_param_hist_bank.sv
// Histogram counter array: 2**AW bins of CW bits, one increment or decrement per cycle.
module counting_sorter_param_hist_bank #(
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          inc_en_i,
  input  logic [AW-1:0] inc_addr_i,
  input  logic          dec_en_i,
  input  logic [AW-1:0] dec_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [CW-1:0] rd_cnt_o
);

  localparam int unsigned NB = 1 << AW;

  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      for (int i = 0; i < NB; i++) cnt_d[i] = '0;
    end else if (inc_en_i) begin
      cnt_d[inc_addr_i] = cnt_q[inc_addr_i] + CW'(1);
    end else if (dec_en_i) begin
      cnt_d[dec_addr_i] = cnt_q[dec_addr_i] - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_cnt_o = cnt_q[rd_addr_i];

endmodule

// File: rtl/counting_sorter_param.sv
// Counting-sort engine: histogram NUM elements, then emit bins in order until NUM slots are filled.
module counting_sorter_param
  import counting_sorter_param_pkg::*;
#(
  parameter int unsigned NUM = 8,
  parameter int unsigned DW  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              desc_i,
  input  logic [NUM*DW-1:0] nums_i,
  output logic              busy_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [NUM*DW-1:0] sorted_nums_o
);

  localparam int unsigned NB = 1 << DW;
  localparam int unsigned CW = cnt_width(NUM);
  localparam int unsigned IW = $clog2(NUM);
  localparam logic [IW-1:0] LastIdx = IW'(NUM - 1);
  localparam logic [DW-1:0] PtrMax  = DW'(NB - 1);

  state_e            state_q, state_d;
  logic              desc_q, desc_d;
  logic [NUM*DW-1:0] nums_q, nums_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     ptr_q, ptr_d;
  logic [NUM*DW-1:0] sorted_q, sorted_d;

  logic [DW-1:0] cur_elem;
  logic [CW-1:0] rd_cnt;
  logic          clear, inc_en, dec_en;

  always_comb begin
    cur_elem = '0;
    for (int k = 0; k < NUM; k++) begin
      if (idx_q == IW'(k)) cur_elem = nums_q[k*DW +: DW];
    end
  end

  always_comb begin
    state_d  = state_q;
    desc_d   = desc_q;
    nums_d   = nums_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    sorted_d = sorted_q;
    clear    = 1'b0;
    inc_en   = 1'b0;
    dec_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          desc_d  = desc_i;
          nums_d  = nums_i;
          clear   = 1'b1;
          idx_d   = '0;
          state_d = StCount;
        end
      end
      StCount: begin
        inc_en = 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          ptr_d   = desc_q ? PtrMax : '0;
          state_d = StEmit;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StEmit: begin
        if (rd_cnt != '0) begin
          dec_en = 1'b1;
          for (int k = 0; k < NUM; k++) begin
            if (idx_q == IW'(k)) sorted_d[k*DW +: DW] = ptr_q;
          end
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          // Only reached while unwritten elements remain, so the pointer cannot run off the end.
          ptr_d = desc_q ? ptr_q - DW'(1) : ptr_q + DW'(1);
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      desc_q   <= 1'b0;
      nums_q   <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      sorted_q <= '0;
    end else begin
      state_q  <= state_d;
      desc_q   <= desc_d;
      nums_q   <= nums_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      sorted_q <= sorted_d;
    end
  end

  counting_sorter_param_hist_bank #(
    .AW (DW),
    .CW (CW)
  ) u_hist_bank (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear),
    .inc_en_i   (inc_en),
    .inc_addr_i (cur_elem),
    .dec_en_i   (dec_en),
    .dec_addr_i (ptr_q),
    .rd_addr_i  (ptr_q),
    .rd_cnt_o   (rd_cnt)
  );

  assign busy_o        = (state_q == StCount) || (state_q == StEmit);
  assign valid_o       = (state_q == StDone);
  assign sorted_nums_o = sorted_q;

endmodule

// File: tb/tb_counting_sorter_param.sv
// Directed and randomised checks of the counting sorter at 8x4 and 16x3 geometries.
module tb_counting_sorter_param;

  localparam int NA = 8;
  localparam int DA = 4;
  localparam int NBN = 16;
  localparam int DBW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                start_a, desc_a, ready_a, busy_a, valid_a;
  logic [NA*DA-1:0]    nums_a, sorted_a;
  logic                start_b, desc_b, ready_b, busy_b, valid_b;
  logic [NBN*DBW-1:0]  nums_b, sorted_b;

  int checks = 0;
  int errors = 0;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];

  counting_sorter_param #(.NUM(NA), .DW(DA)) u_dut_a (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start_a),
    .desc_i        (desc_a),
    .nums_i        (nums_a),
    .busy_o        (busy_a),
    .valid_o       (valid_a),
    .ready_i       (ready_a),
    .sorted_nums_o (sorted_a)
  );

  counting_sorter_param #(.NUM(NBN), .DW(DBW)) u_dut_b (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start_b),
    .desc_i        (desc_b),
    .nums_i        (nums_b),
    .busy_o        (busy_b),
    .valid_o       (valid_b),
    .ready_i       (ready_b),
    .sorted_nums_o (sorted_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sort: plain bubble sort of the unpacked elements.
  function automatic logic [63:0] model_sort(input logic [63:0] nums, input int n, input int dw,
                                             input bit desc);
    int v[16];
    int t;
    logic [63:0] r;
    for (int i = 0; i < n; i++) v[i] = int'(nums >> (i * dw)) & ((1 << dw) - 1);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n - 1 - i; j++) begin
        if (desc ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    r = '0;
    for (int i = 0; i < n; i++) r = r | (64'(v[i]) << (i * dw));
    return r;
  endfunction

  // Edges from start to valid: 1 + n count + n writes + empty bins stepped before the last write.
  function automatic int model_lat(input logic [63:0] nums, input int n, input int dw,
                                   input bit desc);
    int mx, mn, e;
    mx = 0;
    mn = (1 << dw) - 1;
    for (int i = 0; i < n; i++) begin
      e = int'(nums >> (i * dw)) & ((1 << dw) - 1);
      if (e > mx) mx = e;
      if (e < mn) mn = e;
    end
    return 1 + 2 * n + (desc ? ((1 << dw) - 1 - mn) : mx);
  endfunction

  task automatic run_a(input logic [31:0] nums, input bit desc, input int hold, input string tag);
    int lat;
    int exp_lat;
    logic [63:0] e;
    q_a.push_back(model_sort({32'b0, nums}, NA, DA, desc));
    exp_lat = model_lat({32'b0, nums}, NA, DA, desc);
    @(negedge clk);
    start_a = 1'b1; desc_a = desc; nums_a = nums;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start_a = 1'b0; desc_a = ~desc; nums_a = ~nums;
    chk({tag, "_busy"}, busy_a, 1);
    while (!valid_a && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_done_busy"}, busy_a, 0);
    e = q_a.pop_front();
    chk({tag, "_sorted"}, {32'b0, sorted_a}, e);
    if (hold > 0) begin
      start_a = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk({tag, "_hold_valid"}, valid_a, 1);
      chk({tag, "_hold_sorted"}, {32'b0, sorted_a}, e);
      chk({tag, "_hold_busy"}, busy_a, 0);
    end
    ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_a = 1'b0;
    start_a = 1'b0;
    chk({tag, "_post_valid"}, valid_a, 0);
    chk({tag, "_post_busy"}, busy_a, 0);
  endtask

  initial begin
    int lat;
    int guard;
    bit hs;
    bit desc;
    logic [47:0] nb;
    logic [63:0] e;

    rst_n = 1'b0;
    start_a = 0; desc_a = 0; ready_a = 0; nums_a = '0;
    start_b = 0; desc_b = 0; ready_b = 0; nums_b = '0;
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_sorted", {32'b0, sorted_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_a(32'hC193_0F37, 1'b0, 0, "asc");
    run_a(32'hC193_0F37, 1'b1, 0, "desc");
    run_a(32'h5555_5555, 1'b0, 0, "all5");
    run_a(32'h2A6E_4B18, 1'b0, 10, "hold");

    // Abort in the middle of the emit phase.
    @(negedge clk);
    start_a = 1'b1; desc_a = 1'b0; nums_a = 32'h7654_3210;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (NA + 2) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_busy", busy_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_valid", valid_a, 0);
    chk("abort_sorted", {32'b0, sorted_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(32'h0F1E_2D3C, 1'b1, 0, "after_abort");

    for (int j = 0; j < 200; j++) begin
      nb = {16'($urandom), 32'($urandom)};
      desc = 1'($urandom_range(0, 1));
      q_b.push_back(model_sort({16'b0, nb}, NBN, DBW, desc));
      @(negedge clk);
      start_b = 1'b1; desc_b = desc; nums_b = nb;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start_b = 1'b0; nums_b = 48'($urandom);
      while (!valid_b && lat < 100) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      chk("rnd_lat", lat, model_lat({16'b0, nb}, NBN, DBW, desc));
      chk("rnd_lat_bound", (lat <= 1 + 2 * NBN + (1 << DBW) - 1), 1);
      hs = 0;
      guard = 0;
      while (!hs && guard < 50) begin
        ready_b = 1'($urandom_range(0, 1));
        if (ready_b) begin
          e = q_b.pop_front();
          chk("rnd_sorted", {16'b0, sorted_b}, e);
          hs = 1;
        end
        @(posedge clk);
        @(negedge clk);
        ready_b = 1'b0;
        guard++;
      end
      chk("rnd_valid_clear", valid_b, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
